regfile_writeback_queue: RTL and testbench

Write-side producer for the 32x32 integer register file. It collects completed results from the ALU path and the memory/long-latency path, preserves their program order, and drains them one per cycle into the register file's single write port (reg_write / write_reg / write_data). It also reports whether a source register still has an uncommitted write and supplies the youngest matching value for forwarding, because the register file has no internal write-to-read bypass.

---
 rtl/regfile_writeback_queue_pkg.sv | 15 +
 rtl/regfile_writeback_queue_if.sv | 54 +++++
 rtl/regfile_writeback_queue_wb_fifo.sv | 56 +++++
 rtl/regfile_writeback_queue.sv | 111 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/regfile_writeback_queue_pkg.sv
// Shared RV integer-core definitions: register file geometry and the
// write-back entry that travels from the result paths to the register file.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Bundle between the result producers / decode stage (master) and the
// write-back queue (slave): two push paths, register-file write port, forwarding.
interface regfile_writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;

  logic [ADDR_W-1:0] query_rs1;
  logic [ADDR_W-1:0] query_rs2;
  logic              rs1_pending;
  logic              rs2_pending;
  logic [DATA_W-1:0] rs1_fwd_data;
  logic [DATA_W-1:0] rs2_fwd_data;

  logic [CNT_W-1:0]  count;

  modport master (
    output mem_valid, mem_rd, mem_data,
    output alu_valid, alu_rd, alu_data,
    output query_rs1, query_rs2,
    input  mem_ready, alu_ready,
    input  rf_reg_write, rf_write_reg, rf_write_data,
    input  rs1_pending, rs2_pending, rs1_fwd_data, rs2_fwd_data,
    input  count
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data,
    input  alu_valid, alu_rd, alu_data,
    input  query_rs1, query_rs2,
    output mem_ready, alu_ready,
    output rf_reg_write, rf_write_reg, rf_write_data,
    output rs1_pending, rs2_pending, rs1_fwd_data, rs2_fwd_data,
    output count
  );

endinterface

// File: rtl/regfile_writeback_queue_wb_fifo.sv
// Circular buffer with two ordered push ports and one pop port. Entries are
// presented oldest-first (index 0 = head) together with an occupancy mask.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push0,
  input  wb_entry_t        i_entry0,
  input  logic             i_push1,
  input  wb_entry_t        i_entry1,
  input  logic             i_pop,
  output wb_entry_t        o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_slot1;

  // Port 1 lands behind port 0 when both push, otherwise at the tail itself.
  assign w_slot1 = i_push0 ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wr_ptr] <= i_entry0;
    if (i_push1) r_mem[w_slot1]  <= i_entry1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_push0) + PTR_W'(i_push1);
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
      r_count  <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    assign o_entries[k] = r_mem[r_rd_ptr + PTR_W'(k)];
    assign o_valid[k]   = (CNT_W'(k) < r_count);
  end

  assign o_count = r_count;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Ordered write-back queue feeding the register file's single write port,
// with pending/forwarding lookup over everything not yet committed.
module regfile_writeback_queue
  import rv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_writeback_queue_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_free;
  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_pop;
  wb_entry_t         w_entries [DEPTH];
  logic [DEPTH-1:0]  w_valid;
  logic [DATA_W:0]   w_fwd1;
  logic [DATA_W:0]   w_fwd2;

  logic              r_rf_vld_p1;
  logic [ADDR_W-1:0] r_rf_rd_p1;
  logic [DATA_W-1:0] r_rf_data_p1;

  // Youngest match wins: rf stage first, then queue head-to-tail overwrites it.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [ADDR_W-1:0] rs,
    input wb_entry_t         ents [DEPTH],
    input logic [DEPTH-1:0]  vld,
    input logic              rf_vld,
    input logic [ADDR_W-1:0] rf_rd,
    input logic [DATA_W-1:0] rf_data
  );
    logic              hit;
    logic [DATA_W-1:0] data;
    hit  = 1'b0;
    data = '0;
    if (rf_vld && rf_rd == rs) begin
      hit  = 1'b1;
      data = rf_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k] && ents[k].rd == rs) begin
        hit  = 1'b1;
        data = ents[k].data;
      end
    end
    return {hit && (rs != REG_X0), data};
  endfunction

  // Readiness uses registered occupancy only; a same-cycle pop frees nothing.
  assign w_free        = DEPTH_C - w_count;
  assign bus.mem_ready = (w_free >= CNT_W'(1));
  assign bus.alu_ready = (w_free >= CNT_W'(2)) || (w_free == CNT_W'(1) && !bus.mem_valid);

  assign w_mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_rd != REG_X0);
  assign w_alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != REG_X0);
  assign w_pop      = (w_count != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push0   (w_mem_push),
    .i_entry0  ('{rd: bus.mem_rd, data: bus.mem_data}),
    .i_push1   (w_alu_push),
    .i_entry1  ('{rd: bus.alu_rd, data: bus.alu_data}),
    .i_pop     (w_pop),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_count   (w_count)
  );

  // Stage p1: register-file write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_vld_p1  <= 1'b0;
      r_rf_rd_p1   <= '0;
      r_rf_data_p1 <= '0;
    end else begin
      r_rf_vld_p1 <= w_pop;
      if (w_pop) begin
        r_rf_rd_p1   <= w_entries[0].rd;
        r_rf_data_p1 <= w_entries[0].data;
      end
    end
  end

  assign w_fwd1 = fwd_lookup(bus.query_rs1, w_entries, w_valid, r_rf_vld_p1, r_rf_rd_p1, r_rf_data_p1);
  assign w_fwd2 = fwd_lookup(bus.query_rs2, w_entries, w_valid, r_rf_vld_p1, r_rf_rd_p1, r_rf_data_p1);

  assign bus.rs1_pending   = w_fwd1[DATA_W];
  assign bus.rs1_fwd_data  = w_fwd1[DATA_W-1:0];
  assign bus.rs2_pending   = w_fwd2[DATA_W];
  assign bus.rs2_fwd_data  = w_fwd2[DATA_W-1:0];

  assign bus.rf_reg_write  = r_rf_vld_p1;
  assign bus.rf_write_reg  = r_rf_rd_p1;
  assign bus.rf_write_data = r_rf_data_p1;
  assign bus.count         = w_count;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for the write-back queue: commits are checked in order
// against a scoreboard filled as handshakes are predicted.
module tb_regfile_writeback_queue;
  import rv_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int        n_pass  = 0;
  int        n_total = 0;
  int        n_fail  = 0;
  int        mcount  = 0;
  wb_entry_t sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every commit must be the oldest outstanding expected write.
  always @(negedge clk) begin
    wb_entry_t e;
    if (!reset) begin
      if (bus.rf_reg_write) begin
        chk("commit_not_x0", 32'(bus.rf_write_reg != 5'd0), 32'd1);
        if (sb.size() == 0) begin
          chk("commit_unexpected", 32'(bus.rf_reg_write), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("commit_rd", 32'(bus.rf_write_reg), 32'(e.rd));
          chk("commit_data", bus.rf_write_data, e.data);
        end
      end
      chk("count_bound", 32'(bus.count <= 3'(DEPTH)), 32'd1);
    end
  end

  task automatic cyc(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic av, input logic [4:0] ard, input logic [31:0] ad);
    int   free;
    int   enq;
    logic emr;
    logic ear;
    bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = md;
    bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
    #1;
    free = DEPTH - mcount;
    emr  = (free >= 1);
    ear  = (free >= 2) || (free == 1 && !mv);
    chk("mem_ready", 32'(bus.mem_ready), 32'(emr));
    chk("alu_ready", 32'(bus.alu_ready), 32'(ear));
    enq = 0;
    if (mv && emr && mrd != 5'd0) begin sb.push_back('{rd: mrd, data: md}); enq++; end
    if (av && ear && ard != 5'd0) begin sb.push_back('{rd: ard, data: ad}); enq++; end
    @(posedge clk);
    #1;
    mcount = mcount + enq - ((mcount > 0) ? 1 : 0);
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    chk("count", 32'(bus.count), 32'(mcount));
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    bus.mem_valid = 1'b0;  bus.mem_rd = '0;  bus.mem_data = '0;
    bus.alu_valid = 1'b0;  bus.alu_rd = '0;  bus.alu_data = '0;
    bus.query_rs1 = '0;    bus.query_rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_reg_write", 32'(bus.rf_reg_write), 32'd0);
    chk("rst_write_reg", 32'(bus.rf_write_reg), 32'd0);
    chk("rst_write_data", bus.rf_write_data, 32'd0);
    reset = 1'b0;

    // Single ALU result: two-edge latency to the register file
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    chk("t1_e1_wr", 32'(bus.rf_reg_write), 32'd0);
    idle();
    chk("t1_e2_wr", 32'(bus.rf_reg_write), 32'd1);
    chk("t1_e2_reg", 32'(bus.rf_write_reg), 32'd7);
    chk("t1_e2_data", bus.rf_write_data, 32'h1234);
    idle();
    chk("t1_e3_wr", 32'(bus.rf_reg_write), 32'd0);

    // Dual push to the same rd: mem is older, ALU value is the youngest
    bus.query_rs1 = 5'd3;
    bus.query_rs2 = 5'd9;
    cyc(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
    chk("t2_q_pend", 32'(bus.rs1_pending), 32'd1);
    chk("t2_q_fwd", bus.rs1_fwd_data, 32'hBBBB);
    chk("t2_rs2_pend", 32'(bus.rs2_pending), 32'd0);
    idle();
    chk("t2_c1_data", bus.rf_write_data, 32'hAAAA);
    chk("t2_c1_fwd", bus.rs1_fwd_data, 32'hBBBB);
    chk("t2_c1_pend", 32'(bus.rs1_pending), 32'd1);
    idle();
    chk("t2_c2_data", bus.rf_write_data, 32'hBBBB);
    chk("t2_c2_fwd", bus.rs1_fwd_data, 32'hBBBB);
    chk("t2_c2_pend", 32'(bus.rs1_pending), 32'd1);
    idle();
    chk("t2_done_pend", 32'(bus.rs1_pending), 32'd0);
    chk("t2_done_fwd", bus.rs1_fwd_data, 32'd0);
    chk("t2_rs2_fwd", bus.rs2_fwd_data, 32'd0);

    // Sustained dual input: ALU path gets throttled once occupancy reaches 3
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 5'(10 + i), 32'h1000 + i, 1'b1, 5'(20 + i), 32'h2000 + i);
    repeat (4) idle();

    // x0 results are accepted but never queued or committed
    bus.query_rs1 = 5'd0;
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    chk("x0_pend", 32'(bus.rs1_pending), 32'd0);
    cyc(1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd5, 32'h55);
    repeat (3) idle();

    // Pointer wrap with a stream of single results
    for (int r = 1; r <= 10; r++)
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), r * 32'h11);
    repeat (3) idle();
    chk("wrap_all_committed", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-operation discards the queue
    cyc(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
    cyc(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_wr", 32'(bus.rf_reg_write), 32'd0);
    chk("mrst_count", 32'(bus.count), 32'd0);
    chk("mrst_reg", 32'(bus.rf_write_reg), 32'd0);
    sb.delete();
    mcount = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (4) idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
